// File: rtl/mod179_pkg.sv
// Shared types and constants for the mod179 feeder slice.
package mod179_pkg;

  localparam int unsigned XW = 16;
  localparam int unsigned ZW = 8;
  localparam logic [ZW-1:0] MODULUS = 8'd179;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } feeder_state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [ZW-1:0] z;
  } result_t;

  // A legal residue is strictly below the modulus.
  function automatic logic residue_ok(input logic [ZW-1:0] z);
    return z < MODULUS;
  endfunction

endpackage

// File: rtl/mod179_fifo.sv
// Synchronous FIFO with registered occupancy; head word is read combinationally.
module mod179_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_c;
  logic          do_push_c;
  logic          do_pop_c;

  assign full_c    = (count_q == CW'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign do_push_c = push_i && !full_c;
  assign do_pop_c  = pop_i && !empty_c;
  assign rdata_c   = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mod179_feeder.sv
// Sequencer that feeds buffered operands to the mod179 core one at a time,
// captures each residue, and supervises the core with a watchdog and range check.
module mod179_feeder
  import mod179_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [15:0]   in_x,
  output logic          in_ready,
  output logic [15:0]   core_x,
  output logic          core_start,
  input  logic          core_done,
  input  logic [7:0]    core_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_x,
  output logic [7:0]    out_z,
  output logic          busy,
  output logic          err_timeout,
  output logic          err_range
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT) + 1;

  feeder_state_t state_q, state_d;
  logic [XW-1:0] core_x_q, core_x_d;
  result_t       res_q, res_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic          err_t_q, err_t_d;
  logic          err_r_q, err_r_d;

  logic [XW-1:0] fifo_rdata_c;
  logic          fifo_empty_c;
  logic [CW-1:0] fifo_count;
  logic          pop_c;

  mod179_fifo #(
    .W     (XW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (in_valid),
    .wdata_i (in_x),
    .pop_i   (pop_c),
    .rdata_c (fifo_rdata_c),
    .empty_c (fifo_empty_c),
    .count_o (fifo_count)
  );

  // Status outputs are pure decodes of registered state.
  assign in_ready    = (fifo_count != CW'(DEPTH));
  assign core_start  = (state_q == ISSUE);
  assign out_valid   = (state_q == OUT);
  assign busy        = (state_q != IDLE);
  assign core_x      = core_x_q;
  assign out_x       = res_q.x;
  assign out_z       = res_q.z;
  assign err_timeout = err_t_q;
  assign err_range   = err_r_q;

  always_comb begin
    state_d  = state_q;
    core_x_d = core_x_q;
    res_d    = res_q;
    wd_d     = wd_q;
    err_t_d  = err_t_q;
    err_r_d  = err_r_q;
    pop_c    = 1'b0;
    case (state_q)
      IDLE: begin
        // Wait for the core to drop done so a stale completion is never taken.
        if (!fifo_empty_c && !core_done) begin
          pop_c    = 1'b1;
          core_x_d = fifo_rdata_c;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + WDW'(1);
        if (core_done) begin
          res_d.x = core_x_q;
          res_d.z = core_z;
          if (!residue_ok(core_z)) err_r_d = 1'b1;
          state_d = OUT;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          err_t_d = 1'b1;
          res_d.x = core_x_q;
          res_d.z = '1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      core_x_q <= '0;
      res_q    <= '0;
      wd_q     <= '0;
      err_t_q  <= 1'b0;
      err_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      core_x_q <= core_x_d;
      res_q    <= res_d;
      wd_q     <= wd_d;
      err_t_q  <= err_t_d;
      err_r_q  <= err_r_d;
    end
  end

endmodule

// File: tb/tb_mod179_feeder.sv
// Directed bench for mod179_feeder with a behavioural core (real, hung, or out-of-range).
module tb_mod179_feeder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_x;
  logic        in_ready;
  logic [15:0] core_x;
  logic        core_start;
  logic        core_done;
  logic [7:0]  core_z;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [7:0]  out_z;
  logic        busy;
  logic        err_timeout;
  logic        err_range;

  int n_cmp;
  int n_err;
  int core_mode;   // 0: real residue, 1: never done, 2: always returns 200

  mod179_feeder #(
    .DEPTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_x        (in_x),
    .in_ready    (in_ready),
    .core_x      (core_x),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_z      (core_z),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_z       (out_z),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_range   (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: three cycles after start, a one-cycle done pulse with the residue.
  logic [15:0] lat_x;
  int          lat_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt   <= 0;
      lat_x     <= '0;
      core_done <= 1'b0;
      core_z    <= '0;
    end else if (core_start) begin
      lat_cnt   <= 3;
      lat_x     <= core_x;
      core_done <= 1'b0;
    end else if (lat_cnt == 1) begin
      lat_cnt   <= 0;
      core_done <= (core_mode != 1);
      core_z    <= (core_mode == 2) ? 8'd200 : 8'(lat_x % 179);
    end else begin
      if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
      core_done <= 1'b0;
    end
  end

  typedef struct {
    logic [15:0] x;
    int          mode;
    logic [7:0]  z;
    logic        et;
    logic        er;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] x);
    int n;
    n = 0;
    in_x     = x;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_accepted", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_after_accept", 32'(out_valid), 32'd0);
  endtask

  logic [15:0] burst_x [6];
  logic [7:0]  burst_z [6];

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    core_mode = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b0;

    vecs[0] = '{x: 16'd1000,  mode: 0, z: 8'd105, et: 1'b0, er: 1'b0};
    vecs[1] = '{x: 16'd65534, mode: 0, z: 8'd20,  et: 1'b0, er: 1'b0};
    vecs[2] = '{x: 16'd179,   mode: 0, z: 8'd0,   et: 1'b0, er: 1'b0};
    vecs[3] = '{x: 16'd178,   mode: 0, z: 8'd178, et: 1'b0, er: 1'b0};
    vecs[4] = '{x: 16'd5,     mode: 2, z: 8'd200, et: 1'b0, er: 1'b1};
    vecs[5] = '{x: 16'd358,   mode: 0, z: 8'd0,   et: 1'b0, er: 1'b1};
    vecs[6] = '{x: 16'd500,   mode: 0, z: 8'd142, et: 1'b0, er: 1'b1};

    burst_x[0] = 16'd100; burst_z[0] = 8'd100;
    burst_x[1] = 16'd200; burst_z[1] = 8'd21;
    burst_x[2] = 16'd300; burst_z[2] = 8'd121;
    burst_x[3] = 16'd400; burst_z[3] = 8'd42;
    burst_x[4] = 16'd500; burst_z[4] = 8'd142;
    burst_x[5] = 16'd600; burst_z[5] = 8'd63;

    // Reset values while held in reset.
    #12;
    chk("rst_in_ready",   32'(in_ready),    32'd1);
    chk("rst_busy",       32'(busy),        32'd0);
    chk("rst_out_valid",  32'(out_valid),   32'd0);
    chk("rst_core_start", 32'(core_start),  32'd0);
    chk("rst_core_x",     32'(core_x),      32'd0);
    chk("rst_out_x",      32'(out_x),       32'd0);
    chk("rst_out_z",      32'(out_z),       32'd0);
    chk("rst_err_t",      32'(err_timeout), 32'd0);
    chk("rst_err_r",      32'(err_range),   32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single operands, range check and sticky range flag.
    for (int i = 0; i < 7; i++) begin
      core_mode = vecs[i].mode;
      push_word(vecs[i].x);
      wait_out();
      chk($sformatf("vec%0d_out_x", i), 32'(out_x),       32'(vecs[i].x));
      chk($sformatf("vec%0d_out_z", i), 32'(out_z),       32'(vecs[i].z));
      chk($sformatf("vec%0d_err_t", i), 32'(err_timeout), 32'(vecs[i].et));
      chk($sformatf("vec%0d_err_r", i), 32'(err_range),   32'(vecs[i].er));
      accept();
    end
    core_mode = 0;

    // Burst under backpressure: one word in the core plus four queued fills the FIFO.
    for (int i = 0; i < 5; i++) push_word(burst_x[i]);
    @(negedge clk);
    chk("burst_in_ready_full", 32'(in_ready), 32'd0);
    fork
      push_word(burst_x[5]);
      begin
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          wait_out();
          chk($sformatf("burst%0d_out_x", i), 32'(out_x), 32'(burst_x[i]));
          chk($sformatf("burst%0d_out_z", i), 32'(out_z), 32'(burst_z[i]));
          @(posedge clk);
        end
        #1;
        out_ready = 1'b0;
      end
    join
    @(negedge clk);
    chk("burst_drained_in_ready", 32'(in_ready), 32'd1);

    // Watchdog: hung core times out 16 cycles after the start pulse ends.
    core_mode = 1;
    push_word(16'd1234);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!core_start && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("wd_core_start", 32'(core_start), 32'd1);
      chk("wd_core_x",     32'(core_x),     32'd1234);
    end
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("wd_err_t_early",     32'(err_timeout), 32'd0);
    chk("wd_out_valid_early", 32'(out_valid),   32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("wd_err_t",     32'(err_timeout), 32'd1);
    chk("wd_out_valid", 32'(out_valid),   32'd1);
    chk("wd_out_z",     32'(out_z),       32'hFF);
    chk("wd_out_x",     32'(out_x),       32'd1234);
    chk("wd_err_r",     32'(err_range),   32'd1);
    accept();
    core_mode = 0;
    push_word(16'd1000);
    wait_out();
    chk("post_wd_out_x", 32'(out_x),       32'd1000);
    chk("post_wd_out_z", 32'(out_z),       32'd105);
    chk("post_wd_err_t", 32'(err_timeout), 32'd1);
    accept();

    // Reset mid-WAIT with three words queued.
    core_mode = 1;
    for (int i = 0; i < 4; i++) push_word(16'(i + 1));
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_in_ready",   32'(in_ready),    32'd1);
    chk("mid_rst_busy",       32'(busy),        32'd0);
    chk("mid_rst_out_valid",  32'(out_valid),   32'd0);
    chk("mid_rst_core_start", 32'(core_start),  32'd0);
    chk("mid_rst_core_x",     32'(core_x),      32'd0);
    chk("mid_rst_out_x",      32'(out_x),       32'd0);
    chk("mid_rst_out_z",      32'(out_z),       32'd0);
    chk("mid_rst_err_t",      32'(err_timeout), 32'd0);
    chk("mid_rst_err_r",      32'(err_range),   32'd0);
    @(negedge clk);
    reset     = 1'b1;
    core_mode = 0;
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (out_valid || busy) stale++;
      end
      chk("no_stale_after_reset", 32'(stale), 32'd0);
    end
    push_word(16'd178);
    wait_out();
    chk("post_rst_out_x", 32'(out_x),       32'd178);
    chk("post_rst_out_z", 32'(out_z),       32'd178);
    chk("post_rst_err_t", 32'(err_timeout), 32'd0);
    chk("post_rst_err_r", 32'(err_range),   32'd0);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
